icache_refill_ctrl: RTL and testbench

- Miss/refill controller for the 8-entry fully-associative instruction cache group in the dual-issue fetch stage.
- Watches both fetch read ports and their hit flags, and stalls fetch on any miss.
- Fetches one missing instruction word at a time over an AXI-style read channel (AR/R), then writes it into the cache group via its single write port.
- Picks the victim entry with a round-robin pointer; supports cancellation by pipeline flush.

---
 rtl/icache_refill_ctrl_if.sv | 43 ++++
 rtl/icache_refill_ctrl.sv | 145 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of fetch-port, cache-write-port and AXI AR/R signals seen by the
// I-cache refill controller; master = controller side, slave = environment.
interface icache_refill_ctrl_if #(
   parameter int PTR_W  = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req1_valid_i;
   logic [ADDR_W-1:0] req1_pc_i;
   logic              rt1_i;
   logic              req2_valid_i;
   logic [ADDR_W-1:0] req2_pc_i;
   logic              rt2_i;
   logic              flush_i;
   logic              stall_o;
   logic              we_o;
   logic [PTR_W-1:0]  waddr_o;
   logic [ADDR_W-1:0] wpc_o;
   logic [DATA_W-1:0] winst_o;
   logic              ar_valid_o;
   logic [ADDR_W-1:0] ar_addr_o;
   logic              ar_ready_i;
   logic              r_valid_i;
   logic [DATA_W-1:0] r_data_i;
   logic              r_ready_o;
   logic [31:0]       miss_cnt_o;

   modport master (
      input  req1_valid_i, req1_pc_i, rt1_i,
      input  req2_valid_i, req2_pc_i, rt2_i,
      input  flush_i, ar_ready_i, r_valid_i, r_data_i,
      output stall_o, we_o, waddr_o, wpc_o, winst_o,
      output ar_valid_o, ar_addr_o, r_ready_o, miss_cnt_o
   );

   modport slave (
      output req1_valid_i, req1_pc_i, rt1_i,
      output req2_valid_i, req2_pc_i, rt2_i,
      output flush_i, ar_ready_i, r_valid_i, r_data_i,
      input  stall_o, we_o, waddr_o, wpc_o, winst_o,
      input  ar_valid_o, ar_addr_o, r_ready_o, miss_cnt_o
   );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Miss/refill controller for the fully-associative I-cache group: stalls fetch
// on a miss, refills one word over AR/R and writes it to a round-robin victim.
module icache_refill_ctrl #(
   parameter int ENTRIES = 8,
   parameter int PTR_W   = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   icache_refill_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              miss1_s;
   logic              miss2_s;
   logic              start_s;
   logic              ar_valid_s;
   logic              r_ready_s;
   logic              we_s;
   logic [ADDR_W-1:0] ar_addr_r;
   logic [ADDR_W-1:0] wpc_r;
   logic [DATA_W-1:0] winst_r;
   logic [PTR_W-1:0]  ptr_r;
   logic              discard_r;
   logic [31:0]       miss_cnt_r;

   assign miss1_s = (state_r == ST_IDLE) & bus.req1_valid_i & ~bus.rt1_i;
   assign miss2_s = (state_r == ST_IDLE) & bus.req2_valid_i & ~bus.rt2_i;
   assign start_s = (miss1_s | miss2_s) & ~bus.flush_i;

   // Fetch sees the stall in the same cycle it presents a missing PC.
   assign bus.stall_o    = (state_r != ST_IDLE) | start_s;
   assign bus.ar_valid_o = ar_valid_s;
   assign bus.r_ready_o  = r_ready_s;
   assign bus.we_o       = we_s;
   assign bus.ar_addr_o  = ar_addr_r;
   assign bus.wpc_o      = wpc_r;
   assign bus.winst_o    = winst_r;
   assign bus.waddr_o    = ptr_r;
   assign bus.miss_cnt_o = miss_cnt_r;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a flush coinciding with the data beat still discards it
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_next_s = ST_REQ;
            else         state_next_s = ST_IDLE;
         end
         ST_REQ: begin
            if (bus.ar_ready_i) state_next_s = ST_WAIT;
            else                state_next_s = ST_REQ;
         end
         ST_WAIT: begin
            if (bus.r_valid_i) begin
               if (discard_r | bus.flush_i) state_next_s = ST_IDLE;
               else                         state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_WRITE: state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Handshake and write-enable decode from the registered state
   always_comb begin
      ar_valid_s = 1'b0;
      r_ready_s  = 1'b0;
      we_s       = 1'b0;
      case (state_r)
         ST_IDLE:  we_s       = 1'b0;
         ST_REQ:   ar_valid_s = 1'b1;
         ST_WAIT:  r_ready_s  = 1'b1;
         ST_WRITE: we_s       = 1'b1;
         default: begin
            ar_valid_s = 1'b0;
            r_ready_s  = 1'b0;
            we_s       = 1'b0;
         end
      endcase
   end

   // Miss address, refill data, victim pointer and miss counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ar_addr_r  <= {ADDR_W{1'b0}};
         wpc_r      <= {ADDR_W{1'b0}};
         winst_r    <= {DATA_W{1'b0}};
         ptr_r      <= {PTR_W{1'b0}};
         miss_cnt_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  ar_addr_r  <= miss1_s ? bus.req1_pc_i : bus.req2_pc_i;
                  miss_cnt_r <= miss_cnt_r + 32'd1;
               end
            end
            ST_WAIT: begin
               if (bus.r_valid_i) begin
                  winst_r <= bus.r_data_i;
                  wpc_r   <= ar_addr_r;
               end
            end
            ST_WRITE: begin
               if (ptr_r == PTR_W'(ENTRIES - 1)) ptr_r <= {PTR_W{1'b0}};
               else                              ptr_r <= ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

   // Discard flag: set by a flush during the AXI transaction, cleared on return to IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         discard_r <= 1'b0;
      end else if (state_next_s == ST_IDLE) begin
         discard_r <= 1'b0;
      end else if (((state_r == ST_REQ) || (state_r == ST_WAIT)) && bus.flush_i) begin
         discard_r <= 1'b1;
      end else begin
         discard_r <= discard_r;
      end
   end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl against a transaction-level
// model: expected miss count, round-robin victim index and cache contents.
module tb_icache_refill_ctrl;
   localparam int ENTRIES = 8;
   localparam int PTR_W   = 3;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_refill_ctrl_if #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   icache_refill_ctrl #(.ENTRIES(ENTRIES), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int          total = 0;
   int          bad = 0;
   int          exp_cnt = 0;
   int          exp_ptr = 0;
   logic [31:0] exp_pc = 32'd0;
   logic [31:0] cache_pc [ENTRIES];
   bit          cache_vld [ENTRIES];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit in_cache(input logic [31:0] pc);
      bit hit = 1'b0;
      for (int i = 0; i < ENTRIES; i++) if (cache_vld[i] && cache_pc[i] == pc) hit = 1'b1;
      return hit;
   endfunction

   task automatic idle_inputs();
      bus.req1_valid_i = 1'b0; bus.req1_pc_i = 32'd0; bus.rt1_i = 1'b0;
      bus.req2_valid_i = 1'b0; bus.req2_pc_i = 32'd0; bus.rt2_i = 1'b0;
      bus.flush_i = 1'b0; bus.ar_ready_i = 1'b0; bus.r_valid_i = 1'b0; bus.r_data_i = 32'd0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_stall"}, bus.stall_o, 0);
      chk({tag, "_we"}, bus.we_o, 0);
      chk({tag, "_arv"}, bus.ar_valid_o, 0);
      chk({tag, "_rr"}, bus.r_ready_o, 0);
      chk({tag, "_araddr"}, bus.ar_addr_o, 0);
      chk({tag, "_wpc"}, bus.wpc_o, 0);
      chk({tag, "_winst"}, bus.winst_o, 0);
      chk({tag, "_waddr"}, bus.waddr_o, 0);
      chk({tag, "_cnt"}, bus.miss_cnt_o, 0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      exp_ptr = 0;
      for (int i = 0; i < ENTRIES; i++) cache_vld[i] = 1'b0;
      #1 check_zero("rst");
   endtask

   // One IDLE cycle: present requests, check stall, advance, check miss count.
   task automatic idle_cycle(input bit v1, input logic [31:0] p1, input bit v2,
                             input logic [31:0] p2, input bit fl, output bit started);
      bit m1, m2;
      bus.req1_valid_i = v1; bus.req1_pc_i = p1; bus.rt1_i = in_cache(p1);
      bus.req2_valid_i = v2; bus.req2_pc_i = p2; bus.rt2_i = in_cache(p2);
      bus.flush_i = fl; bus.ar_ready_i = 1'b0; bus.r_valid_i = 1'b0;
      m1 = v1 && !in_cache(p1);
      m2 = v2 && !in_cache(p2);
      started = (m1 || m2) && !fl;
      #1;
      chk("idle_stall", bus.stall_o, {63'd0, started});
      chk("idle_we", bus.we_o, 0);
      chk("idle_arv", bus.ar_valid_o, 0);
      chk("idle_rr", bus.r_ready_o, 0);
      if (started) exp_pc = m1 ? p1 : p2;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      if (started) exp_cnt++;
      chk("miss_cnt", bus.miss_cnt_o, exp_cnt);
   endtask

   // Serve a started refill: REQ for ar_dly stall cycles, WAIT for r_dly, then WRITE.
   task automatic serve(input int ar_dly, input int r_dly, input int fl_cyc, input logic [31:0] data);
      bit disc = 1'b0;
      int k = 0;
      for (int i = 0; i <= ar_dly; i++) begin
         bus.ar_ready_i = (i == ar_dly);
         bus.flush_i = (k == fl_cyc);
         if (k == fl_cyc) disc = 1'b1;
         k++;
         #1;
         chk("req_arv", bus.ar_valid_o, 1);
         chk("req_araddr", bus.ar_addr_o, exp_pc);
         chk("req_rr", bus.r_ready_o, 0);
         chk("req_we", bus.we_o, 0);
         chk("req_stall", bus.stall_o, 1);
         @(posedge clk); #1;
      end
      bus.ar_ready_i = 1'b0;
      for (int i = 0; i <= r_dly; i++) begin
         bus.r_valid_i = (i == r_dly);
         bus.r_data_i = (i == r_dly) ? data : $urandom;
         bus.flush_i = (k == fl_cyc);
         if (k == fl_cyc) disc = 1'b1;
         k++;
         #1;
         chk("wait_rr", bus.r_ready_o, 1);
         chk("wait_arv", bus.ar_valid_o, 0);
         chk("wait_we", bus.we_o, 0);
         chk("wait_stall", bus.stall_o, 1);
         @(posedge clk); #1;
      end
      bus.r_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      if (!disc) begin
         bus.flush_i = 1'($urandom_range(0, 1));
         #1;
         chk("wr_we", bus.we_o, 1);
         chk("wr_waddr", bus.waddr_o, exp_ptr);
         chk("wr_wpc", bus.wpc_o, exp_pc);
         chk("wr_winst", bus.winst_o, data);
         chk("wr_stall", bus.stall_o, 1);
         chk("wr_arv", bus.ar_valid_o, 0);
         cache_pc[exp_ptr] = exp_pc;
         cache_vld[exp_ptr] = 1'b1;
         exp_ptr = (exp_ptr + 1) % ENTRIES;
         @(posedge clk); #1;
         bus.flush_i = 1'b0;
      end
      #1;
      chk("end_we", bus.we_o, 0);
      chk("end_rr", bus.r_ready_o, 0);
      chk("end_arv", bus.ar_valid_o, 0);
   endtask

   initial begin
      bit st;
      logic [31:0] pa, pb;
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      do_reset();

      // Single port-1 miss with immediate AXI responses, then a hit.
      idle_cycle(1'b1, 32'h1C00_0000, 1'b0, 32'd0, 1'b0, st);
      serve(0, 0, -1, 32'h0280_0C0C);
      idle_cycle(1'b1, 32'h1C00_0000, 1'b0, 32'd0, 1'b0, st);
      chk("t1_cnt", bus.miss_cnt_o, 1);

      // Dual miss: port 1 then port 2, entries 0 and 1.
      do_reset();
      idle_cycle(1'b1, 32'h1C00_0000, 1'b1, 32'h1C00_0004, 1'b0, st);
      serve(0, 0, -1, 32'hAAAA_0001);
      idle_cycle(1'b1, 32'h1C00_0000, 1'b1, 32'h1C00_0004, 1'b0, st);
      serve(1, 1, -1, 32'hAAAA_0002);
      idle_cycle(1'b1, 32'h1C00_0000, 1'b1, 32'h1C00_0004, 1'b0, st);
      chk("dual_cnt", bus.miss_cnt_o, 2);

      // Same PC on both ports: a single refill.
      idle_cycle(1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0040, 1'b0, st);
      serve(0, 0, -1, 32'hBBBB_0000);
      idle_cycle(1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0040, 1'b0, st);
      chk("same_cnt", bus.miss_cnt_o, 3);

      // Nine distinct misses: victim index walks 0..7 and wraps to 0.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         idle_cycle(1'b1, 32'h2000_0000 + 32'(i * 4), 1'b0, 32'd0, 1'b0, st);
         serve($urandom_range(0, 2), $urandom_range(0, 2), -1, $urandom);
      end
      chk("wrap_ptr_model", bus.waddr_o, 1);

      // ar_ready withheld for 5 REQ cycles, flush in the second one: data dropped.
      do_reset();
      idle_cycle(1'b1, 32'h1C00_0010, 1'b0, 32'd0, 1'b0, st);
      serve(5, 0, 1, 32'hDEAD_BEEF);
      idle_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, st);
      chk("disc_waddr", bus.waddr_o, 0);

      // Flush in the same IDLE cycle as a miss: nothing starts.
      idle_cycle(1'b1, 32'h1C00_0010, 1'b0, 32'd0, 1'b1, st);
      chk("flidle_arv", bus.ar_valid_o, 0);
      idle_cycle(1'b1, 32'h1C00_0010, 1'b0, 32'd0, 1'b0, st);
      serve(0, 2, -1, 32'h1234_5678);

      // Reset while in WAIT: everything clears and a late beat is ignored.
      idle_cycle(1'b1, 32'h1C00_0020, 1'b0, 32'd0, 1'b0, st);
      bus.ar_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ar_ready_i = 1'b0;
      #1 chk("rstw_rr", bus.r_ready_o, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_inputs();
      exp_cnt = 0;
      exp_ptr = 0;
      #1 check_zero("rstw");
      bus.r_valid_i = 1'b1;
      bus.r_data_i = 32'hCAFE_F00D;
      @(posedge clk); #1;
      bus.r_valid_i = 1'b0;
      #1;
      chk("late_we", bus.we_o, 0);
      chk("late_winst", bus.winst_o, 0);
      @(posedge clk); #1;
      chk("late_we2", bus.we_o, 0);

      // Randomized traffic against the model.
      for (int it = 0; it < 250; it++) begin
         int ad, rd, fc;
         pa = 32'h1C00_0000 + 32'($urandom_range(0, 11) * 4);
         pb = 32'h1C00_0000 + 32'($urandom_range(0, 11) * 4);
         idle_cycle(1'($urandom_range(0, 1)), pa, 1'($urandom_range(0, 1)), pb,
                    ($urandom_range(0, 7) == 0), st);
         if (st) begin
            ad = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            fc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ad + rd + 1) : -1;
            serve(ad, rd, fc, $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
